// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// Holds the miss FSM encoding, RV32I access-width codes and index-width helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_DONE      = 2'd3
  } dc_state_e;

  // Loads and stores share the low codes (LB/SB, LH/SH, LW/SW).
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - 2 - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// Storage for one cache way: valid/dirty bits (reset), tags and line data (not reset).
// A single set index serves the read port, the CPU byte-write port and the refill/install port.
module dcache_way_array #(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [$clog2(NUM_SETS)-1:0]       set_i,
  output logic                              rd_valid_o,
  output logic                              rd_dirty_o,
  output logic [TAG_W-1:0]                  rd_tag_o,
  output logic [LINE_WORDS-1:0][31:0]       rd_line_o,
  input  logic                              wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0]     wr_word_i,
  input  logic [3:0]                        wr_be_i,
  input  logic [31:0]                       wr_data_i,
  input  logic                              rf_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0]     rf_word_i,
  input  logic [31:0]                       rf_data_i,
  input  logic                              inst_en_i,
  input  logic [TAG_W-1:0]                  inst_tag_i
);

  logic [NUM_SETS-1:0]          valid_q;
  logic [NUM_SETS-1:0]          dirty_q;
  logic [TAG_W-1:0]             tag_q  [NUM_SETS];
  logic [LINE_WORDS-1:0][31:0]  data_q [NUM_SETS];

  assign rd_valid_o = valid_q[set_i];
  assign rd_dirty_o = dirty_q[set_i];
  assign rd_tag_o   = tag_q[set_i];
  assign rd_line_o  = data_q[set_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en_i) begin
      valid_q[set_i] <= 1'b1;
      dirty_q[set_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[set_i] <= 1'b1;
    end
  end

  // Tags and data survive reset; the cleared valid bits make them unreachable.
  always_ff @(posedge clk_i) begin
    if (inst_en_i) tag_q[set_i] <= inst_tag_i;
    if (rf_en_i) data_q[set_i][rf_word_i] <= rf_data_i;
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_q[set_i][wr_word_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with single-cycle hits,
// word-serial writeback/refill bursts, per-set round-robin replacement and saturating counters.
module data_cache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_SETS, LINE_WORDS);
  localparam int PTR_W  = idx_w(NUM_WAYS);
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  // State register is the FSM observation point for debug and checkers.
  dc_state_e         state_q, state_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [PTR_W-1:0]  victim_q, victim_d;
  logic [PTR_W-1:0]  ptr_q [NUM_SETS];
  logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [1:0]        a_off;
  logic [WORD_W-1:0] a_word;
  logic [SET_W-1:0]  a_set;
  logic [TAG_W-1:0]  a_tag;
  assign a_off  = cpu_addr[1:0];
  assign a_word = cpu_addr[2 +: WORD_W];
  assign a_set  = cpu_addr[2+WORD_W +: SET_W];
  assign a_tag  = cpu_addr[ADDR_W-1 -: TAG_W];

  logic [SET_W-1:0]                         rd_set;
  logic [NUM_WAYS-1:0]                      way_valid, way_dirty;
  logic [NUM_WAYS-1:0][TAG_W-1:0]           way_tag;
  logic [NUM_WAYS-1:0][LINE_WORDS-1:0][31:0] way_line;
  logic              hit_any, hit, miss_go, wr_en, rf_en, inst_en;
  logic [PTR_W-1:0]  hit_way;
  logic [31:0]       hit_word, ld_data, st_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        st_be;

  // Outside IDLE the arrays look at the latched miss set.
  assign rd_set = (state_q == ST_IDLE) ? a_set : set_q;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == a_tag)) begin
        hit_any = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  assign hit       = cpu_req && (state_q == ST_IDLE) && hit_any;
  assign miss_go   = cpu_req && (state_q == ST_IDLE) && !hit_any;
  assign cpu_stall = (cpu_req && !hit) || (state_q != ST_IDLE);
  assign wr_en     = hit && cpu_we;
  assign hit_word  = way_line[hit_way][a_word];
  assign byte_v    = hit_word[{a_off, 3'b000} +: 8];
  assign half_v    = hit_word[{a_off[1], 4'b0000} +: 16];

  always_comb begin
    case (cpu_funct3)
      F3_BYTE:   ld_data = {{24{byte_v[7]}}, byte_v};
      F3_HALF:   ld_data = {{16{half_v[15]}}, half_v};
      F3_BYTE_U: ld_data = {24'h0, byte_v};
      F3_HALF_U: ld_data = {16'h0, half_v};
      default:   ld_data = hit_word;
    endcase
  end
  assign cpu_rdata = hit ? ld_data : 32'h0;

  always_comb begin
    st_be   = 4'b0000;
    st_data = cpu_wdata;
    case (cpu_funct3)
      F3_BYTE: begin
        st_be   = 4'b0001 << a_off;
        st_data = {4{cpu_wdata[7:0]}};
      end
      F3_HALF: begin
        st_be   = a_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cpu_wdata[15:0]}};
      end
      F3_WORD: st_be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    set_d     = set_q;
    tag_d     = tag_q;
    victim_d  = victim_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_en     = 1'b0;
    inst_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_go) begin
          set_d    = a_set;
          tag_d    = a_tag;
          victim_d = ptr_q[a_set];
          beat_d   = '0;
          state_d  = (way_valid[ptr_q[a_set]] && way_dirty[ptr_q[a_set]]) ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {way_tag[victim_q], set_q, beat_q, 2'b00};
        mem_wdata = way_line[victim_q][beat_q];
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, set_q, beat_q, 2'b00};
        if (mem_ack) begin
          rf_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            inst_en = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign hit_cnt_d  = (hit && (hit_cnt_q != '1)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
  assign miss_cnt_d = (miss_go && (miss_cnt_q != '1)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      set_q      <= '0;
      tag_q      <= '0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      set_q      <= set_d;
      tag_q      <= tag_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      // A single way keeps its pointer pinned at zero.
      if (inst_en && (NUM_WAYS > 1)) ptr_q[set_q] <= ptr_q[set_q] + 1'b1;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_way_array #(
      .NUM_SETS  (NUM_SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk_i      (clk),
      .rst_ni     (rst),
      .set_i      (rd_set),
      .rd_valid_o (way_valid[w]),
      .rd_dirty_o (way_dirty[w]),
      .rd_tag_o   (way_tag[w]),
      .rd_line_o  (way_line[w]),
      .wr_en_i    (wr_en && (hit_way == PTR_W'(w))),
      .wr_word_i  (a_word),
      .wr_be_i    (st_be),
      .wr_data_i  (st_data),
      .rf_en_i    (rf_en && (victim_q == PTR_W'(w))),
      .rf_word_i  (beat_q),
      .rf_data_i  (mem_rdata),
      .inst_en_i  (inst_en && (victim_q == PTR_W'(w))),
      .inst_tag_i (tag_q)
    );
  end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Bench for data_cache_assoc: directed vector table, hand-written reset/saturation sequences,
// and random traffic scored against an architectural memory plus FIFO-per-set residency model.
module tb_data_cache_assoc;

  localparam int LW   = 4;
  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  data_cache_assoc dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- backing memory and responder ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] bk [bit [31:0]];
  beat_t       beat_log[$];
  bit          ack_always = 1'b1;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bk_read(input logic [31:0] wa);
    if (bk.exists(wa)) return bk[wa];
    return init_word(wa);
  endfunction

  always @(negedge clk) begin
    if (mem_req && (ack_always || ($urandom_range(0, 3) != 0))) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        bk[mem_addr >> 2] = mem_wdata;
        mem_rdata = 32'h0;
        beat_log.push_back('{1'b1, mem_addr, mem_wdata});
      end else begin
        mem_rdata = bk_read(mem_addr >> 2);
        beat_log.push_back('{1'b0, mem_addr, mem_rdata});
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output logic [31:0] rdata,
                           output int stalls, output logic timeout);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
    stalls = 0; timeout = 1'b0; n = 0;
    @(negedge clk);
    while (cpu_stall && n < 500) begin
      stalls++; n++;
      @(negedge clk);
    end
    timeout = cpu_stall;
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model helpers ----------------
  logic [31:0] arch [bit [31:0]];
  logic [31:0] res_q [SETS][$];
  bit          dirty_m [bit [31:0]];

  function automatic logic [31:0] arch_read(input logic [31:0] wa);
    if (arch.exists(wa)) return arch[wa];
    return bk_read(wa);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100: return b;
      3'b101: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [1:0] off,
                                            input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    case (f3)
      3'b000: begin
        mask = 32'hFF << (8 * off);
        return (old & ~mask) | ((wd & 32'hFF) << (8 * off));
      end
      3'b001: begin
        mask = 32'hFFFF << (16 * off[1]);
        return (old & ~mask) | ((wd & 32'hFFFF) << (16 * off[1]));
      end
      default: return wd;
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        miss;
    logic        wb;
    logic [31:0] wb_base;
    logic [31:0] wb_word0;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [31:0] rd;
  int          stalls, n_rd, n_wr, exp_miss_cnt, exp_stalls;
  logic        to;
  int          m_hit, m_miss;

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    for (int k = 0; k < LW; k++) begin
      bk[(32'h100 >> 2) + k]  = 32'hA0 + k;
      bk[(32'h900 >> 2) + k]  = 32'hB0 + k;
      bk[(32'h1100 >> 2) + k] = 32'hC0 + k;
      bk[(32'h200 >> 2) + k]  = 32'hD0 + k;
    end

    //           we    addr        wdata     f3      chk   rdata          miss  wb    wb_base   wb_word0
    vecs[0]  = '{1'b0, 32'h100,  32'h0,    3'b010, 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[1]  = '{1'b0, 32'h104,  32'h0,    3'b010, 1'b1, 32'h0000_00A1, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[2]  = '{1'b1, 32'h101,  32'hFF,   3'b000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   32'h0};
    vecs[3]  = '{1'b0, 32'h101,  32'h0,    3'b000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[4]  = '{1'b0, 32'h101,  32'h0,    3'b100, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[5]  = '{1'b0, 32'h100,  32'h0,    3'b001, 1'b1, 32'hFFFF_FFA0, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[6]  = '{1'b0, 32'h102,  32'h0,    3'b101, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[7]  = '{1'b0, 32'h100,  32'h0,    3'b010, 1'b1, 32'h0000_FFA0, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[8]  = '{1'b0, 32'h900,  32'h0,    3'b010, 1'b1, 32'h0000_00B0, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[9]  = '{1'b0, 32'h1100, 32'h0,    3'b010, 1'b1, 32'h0000_00C0, 1'b1, 1'b1, 32'h100, 32'h0000_FFA0};
    vecs[10] = '{1'b0, 32'h900,  32'h0,    3'b010, 1'b1, 32'h0000_00B0, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[11] = '{1'b0, 32'h100,  32'h0,    3'b010, 1'b1, 32'h0000_FFA0, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[12] = '{1'b1, 32'h202,  32'hBEEF, 3'b001, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   32'h0};
    vecs[13] = '{1'b0, 32'h200,  32'h0,    3'b010, 1'b1, 32'hBEEF_00D0, 1'b0, 1'b0, 32'h0,   32'h0};

    // Reset state, with a request held so stall must follow it.
    cpu_req = 1'b1;
    #2;
    check("rst_stall", cpu_stall, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    exp_miss_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      beat_log.delete();
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, stalls, to);
      check($sformatf("v%0d_timeout", i), to, 1'b0);
      check($sformatf("v%0d_miss", i), stalls != 0, vecs[i].miss);
      exp_stalls = vecs[i].miss ? (2 + LW + (vecs[i].wb ? LW : 0)) : 0;
      check($sformatf("v%0d_stalls", i), stalls, exp_stalls);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      n_rd = 0; n_wr = 0;
      for (int k = 0; k < beat_log.size(); k++) if (beat_log[k].we) n_wr++; else n_rd++;
      check($sformatf("v%0d_rd_beats", i), n_rd, vecs[i].miss ? LW : 0);
      check($sformatf("v%0d_wr_beats", i), n_wr, vecs[i].wb ? LW : 0);
      if (beat_log.size() == n_wr + n_rd && n_rd == (vecs[i].miss ? LW : 0)
          && n_wr == (vecs[i].wb ? LW : 0)) begin
        for (int k = 0; k < n_wr; k++) begin
          check($sformatf("v%0d_wb_we%0d", i, k), beat_log[k].we, 1'b1);
          check($sformatf("v%0d_wb_addr%0d", i, k), beat_log[k].addr, vecs[i].wb_base + 4 * k);
        end
        if (n_wr > 0) check($sformatf("v%0d_wb_data0", i), beat_log[0].data, vecs[i].wb_word0);
        for (int k = 0; k < n_rd; k++)
          check($sformatf("v%0d_rf_addr%0d", i, k), beat_log[n_wr + k].addr,
                (vecs[i].addr & 32'hFFFF_FFF0) + 4 * k);
      end
      if (vecs[i].miss) exp_miss_cnt++;
      check($sformatf("v%0d_hit_count", i), hit_count, i + 1);
      check($sformatf("v%0d_miss_count", i), miss_count, exp_miss_cnt);
    end

    // Reset in the middle of a refill burst (beat 2 in flight).
    pulse_reset();
    beat_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_funct3 = 3'b010;
    for (int n = 0; n < 50 && beat_log.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_reached_beat2", beat_log.size(), 2);
    check("mid_rst_miss_before", miss_count, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_stall", cpu_stall, 1'b1);
    check("mid_rst_misses", miss_count, 32'h0);
    check("mid_rst_hits", hit_count, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'h100, 32'h0, 3'b010, rd, stalls, to);
    check("post_rst_stalls", stalls, 2 + LW);
    check("post_rst_rdata", rd, 32'h0000_FFA0);
    check("post_rst_misses", miss_count, 32'd1);
    check("post_rst_hits", hit_count, 32'd1);

    // Dropped request mid-miss: line still installed, next access hits.
    beat_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h1234_5678; cpu_funct3 = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    for (int n = 0; n < 50 && dut.cpu_stall; n++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    do_access(1'b0, 32'h300, 32'h0, 3'b010, rd, stalls, to);
    check("drop_hit_stalls", stalls, 0);
    check("drop_no_write", rd, bk_read(32'h300 >> 2));

    // Miss counter saturation.
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.miss_cnt_q;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b0, 32'h3000 + 16 * k, 32'h0, 3'b010, rd, stalls, to);
      check($sformatf("sat_miss%0d", k), miss_count, 32'hFFFF_FFFF);
    end

    // Random traffic against the reference model.
    pulse_reset();
    arch.delete();
    dirty_m.delete();
    for (int s = 0; s < SETS; s++) res_q[s].delete();
    m_hit = 0; m_miss = 0;
    ack_always = 1'b0;
    for (int t = 0; t < 300; t++) begin
      int          kind, set_i, tg, wd, exp_wr;
      logic [1:0]  off;
      logic [2:0]  f3;
      logic        we, hit_m;
      logic [31:0] addr, wdata, line, ev, exp_ld;
      set_i = $urandom_range(0, 3); tg = $urandom_range(0, 4); wd = $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      wdata = $urandom;
      case (kind)
        0: begin f3 = 3'b000; we = 0; off = 2'($urandom_range(0, 3)); end
        1: begin f3 = 3'b001; we = 0; off = {1'($urandom_range(0, 1)), 1'b0}; end
        2: begin f3 = 3'b010; we = 0; off = 2'b00; end
        3: begin f3 = 3'b100; we = 0; off = 2'($urandom_range(0, 3)); end
        4: begin f3 = 3'b101; we = 0; off = {1'($urandom_range(0, 1)), 1'b0}; end
        5: begin f3 = 3'b000; we = 1; off = 2'($urandom_range(0, 3)); end
        6: begin f3 = 3'b001; we = 1; off = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin f3 = 3'b010; we = 1; off = 2'b00; end
      endcase
      addr = 32'h4000 + tg * 1024 + set_i * 16 + wd * 4 + {30'h0, off};
      line = addr >> 4;
      hit_m = 1'b0;
      for (int k = 0; k < res_q[line % SETS].size(); k++)
        if (res_q[line % SETS][k] == line) hit_m = 1'b1;
      exp_wr = 0;
      if (!hit_m) begin
        if (res_q[line % SETS].size() == WAYS) begin
          ev = res_q[line % SETS].pop_front();
          if (dirty_m.exists(ev) && dirty_m[ev]) exp_wr = LW;
          dirty_m[ev] = 1'b0;
        end
        res_q[line % SETS].push_back(line);
        dirty_m[line] = 1'b0;
        m_miss++;
      end
      m_hit++;
      exp_ld = load_val(arch_read(addr >> 2), off, f3);
      if (we) begin
        dirty_m[line] = 1'b1;
        arch[addr >> 2] = store_val(arch_read(addr >> 2), off, f3, wdata);
      end

      beat_log.delete();
      do_access(we, addr, wdata, f3, rd, stalls, to);
      check($sformatf("r%0d_timeout", t), to, 1'b0);
      check($sformatf("r%0d_miss", t), stalls != 0, !hit_m);
      if (!we) check($sformatf("r%0d_rdata", t), rd, exp_ld);
      n_rd = 0; n_wr = 0;
      for (int k = 0; k < beat_log.size(); k++) if (beat_log[k].we) n_wr++; else n_rd++;
      check($sformatf("r%0d_rd_beats", t), n_rd, hit_m ? 0 : LW);
      check($sformatf("r%0d_wr_beats", t), n_wr, exp_wr);
    end
    check("rand_hit_count", hit_count, m_hit);
    check("rand_miss_count", miss_count, m_miss);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
